fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly downstream of program_counter.
- Owns the fetch address, issues word reads to instruction memory over a req/gnt/rvalid handshake, and buffers the returned instructions with their PCs in a small in-order queue.
- Presents instructions to decode with a valid/ready handshake.
- Branch/jump redirects flush the queue and discard in-flight responses.

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with credit-limited requests and in-order queue
//
// Purpose:
//   Owns the fetch PC and issues word reads to instruction memory over a
//   req/gnt/rvalid handshake. It buffers the returned words together with
//   their PCs in a DEPTH-entry in-order queue, and hands them to decode with
//   valid/ready. A redirect flushes the queue and marks every response still
//   in flight for discard.
//
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   imem_req_o / imem_addr_o         fetch request and word-aligned address
//   imem_gnt_i                       memory accepted the request this cycle
//   imem_rvalid_i / imem_rdata_i     in-order read response
//   redirect_i / redirect_pc_i       flush and restart fetch at a new PC
//   instr_valid_o / instr_ready_i    decode handshake on the queue head
//   instr_o / instr_pc_o             head instruction and its PC
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  // Fetch PC, in-flight PC FIFO and instruction queue state.
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] ifl_pc_q [DEPTH];
  logic [AW-1:0]   ifl_wr_q, ifl_rd_q;
  logic [XLEN-1:0] q_pc_q [DEPTH];
  logic [31:0]     q_instr_q [DEPTH];
  logic [AW-1:0]   q_wr_q, q_rd_q;
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   disc_q, disc_d;

  logic            grant;
  logic            q_push;
  logic            q_pop;
  logic [CW:0]     credit_sum;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Every queued entry and every outstanding request holds one queue slot,
  // so a returning response always finds room and the queue cannot overflow.
  assign credit_sum    = {1'b0, occ_q} + {1'b0, out_q};
  assign imem_req_o    = reset_n && !redirect_i && (credit_sum < DEPTH_L);
  assign imem_addr_o   = fetch_pc_q;
  assign grant         = imem_req_o && imem_gnt_i;

  // Responses are dropped in a redirect cycle and while discards are pending.
  assign q_push        = imem_rvalid_i && !redirect_i && (disc_q == '0);

  assign instr_valid_o = reset_n && !redirect_i && (occ_q != '0);
  assign q_pop         = instr_valid_o && instr_ready_i;
  assign instr_o       = q_instr_q[q_rd_q];
  assign instr_pc_o    = q_pc_q[q_rd_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    disc_d     = disc_q;
    // Outstanding tracks real memory traffic, flushed or not; a grant and a
    // response in the same cycle belong to different requests and cancel.
    out_d      = out_q + CW'(grant) - CW'(imem_rvalid_i);
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      occ_d      = '0;
      // Whatever is still in flight after this cycle is stale.
      disc_d     = out_q - CW'(imem_rvalid_i);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (imem_rvalid_i && (disc_q != '0)) begin
        disc_d = disc_q - 1'b1;
      end
      occ_d = occ_q + CW'(q_push) - CW'(q_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      ifl_wr_q   <= '0;
      ifl_rd_q   <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
      occ_q      <= '0;
      out_q      <= '0;
      disc_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ifl_pc_q[i]  <= '0;
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      disc_q     <= disc_d;

      if (grant) begin
        ifl_pc_q[ifl_wr_q] <= fetch_pc_q;
        ifl_wr_q           <= ifl_wr_q + 1'b1;
      end
      // The in-flight entry is retired on every response, kept or dropped.
      if (imem_rvalid_i) begin
        ifl_rd_q <= ifl_rd_q + 1'b1;
      end

      if (redirect_i) begin
        q_wr_q <= '0;
        q_rd_q <= '0;
      end else begin
        if (q_push) begin
          q_pc_q[q_wr_q]    <= ifl_pc_q[ifl_rd_q];
          q_instr_q[q_wr_q] <= imem_rdata_i;
          q_wr_q            <= q_wr_q + 1'b1;
        end
        if (q_pop) begin
          q_rd_q <= q_rd_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_gnt;
  logic [31:0] mq[$];
  bit          resp_en;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o)
  );

  fetch_unit #(.XLEN(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req_o   (w_req),
    .imem_addr_o  (w_addr),
    .imem_gnt_i   (1'b1),
    .imem_rvalid_i(1'b0),
    .imem_rdata_i (32'h0),
    .redirect_i   (1'b0),
    .redirect_pc_i(32'h0),
    .instr_valid_o(w_valid),
    .instr_ready_i(1'b1),
    .instr_o      (w_instr),
    .instr_pc_o   (w_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: answers granted requests in order, at the earliest one
  // cycle after the grant, with data = address ^ 0xA5A5A5A5.
  task automatic drive();
    imem_rvalid_i = resp_en && (mq.size() > 0);
    imem_rdata_i  = imem_rvalid_i ? (mq[0] ^ 32'hA5A5_A5A5) : 32'h0;
    #1;
  endtask

  task automatic adv();
    logic        g;
    logic [31:0] a;
    g = imem_req_o && imem_gnt_i;
    a = imem_addr_o;
    if (g) n_gnt++;
    @(posedge clk);
    if (!reset_n) begin
      mq.delete();
    end else begin
      if (imem_rvalid_i) void'(mq.pop_front());
      if (g) mq.push_back(a);
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n       = 1'b0;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b1;
    resp_en       = 1'b1;
    n_gnt         = 0;

    // Reset state
    @(negedge clk);
    drive(); adv();
    drive();
    chk("rst_req",   {31'b0, imem_req_o},    32'h0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("rst_instr", instr_o,                32'h0);
    chk("rst_pc",    instr_pc_o,             32'h0);
    chk("rst_addr",  imem_addr_o,            32'h0);
    chk("rst_waddr", w_addr,                 32'hFFFF_FFF8);
    adv();

    // Streaming with gnt=1, latency 1, ready=1
    reset_n = 1'b1;
    drive();
    chk("s1_req",   {31'b0, imem_req_o},    32'h1);
    chk("s1_addr",  imem_addr_o,            32'h0);
    chk("s1_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("w1_addr",  w_addr,                 32'hFFFF_FFF8);
    adv();
    drive();
    chk("s2_req",   {31'b0, imem_req_o},    32'h1);
    chk("s2_addr",  imem_addr_o,            32'h4);
    chk("w2_addr",  w_addr,                 32'hFFFF_FFFC);
    chk("w2_req",   {31'b0, w_req},         32'h1);
    adv();
    drive();
    chk("s3_req",   {31'b0, imem_req_o},    32'h0);
    chk("s3_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("s3_pc",    instr_pc_o,             32'h0);
    chk("s3_instr", instr_o,                32'hA5A5_A5A5);
    chk("w3_addr",  w_addr,                 32'h0);
    chk("w3_req",   {31'b0, w_req},         32'h0);
    adv();
    drive();
    chk("s4_addr",  imem_addr_o,            32'h8);
    chk("s4_pc",    instr_pc_o,             32'h4);
    chk("s4_instr", instr_o,                32'hA5A5_A5A1);
    adv();
    drive();
    chk("s5_addr",  imem_addr_o,            32'hC);
    chk("s5_valid", {31'b0, instr_valid_o}, 32'h0);
    adv();
    drive();
    chk("s6_pc",    instr_pc_o,             32'h8);
    chk("s6_instr", instr_o,                32'hA5A5_A5AD);
    adv();

    // Fresh start, decode stalled for 10 cycles
    reset_n = 1'b0;
    drive(); adv();
    reset_n       = 1'b1;
    instr_ready_i = 1'b0;
    n_gnt         = 0;
    for (int i = 0; i < 10; i++) begin
      drive(); adv();
    end
    chk("stall_gnts", n_gnt, 32'd2);
    instr_ready_i = 1'b1;
    drive();
    chk("stall_req",   {31'b0, imem_req_o},    32'h0);
    chk("stall_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("drain_pc0",   instr_pc_o,             32'h0);
    adv();
    drive();
    chk("drain_pc4",   instr_pc_o,             32'h4);
    chk("drain_instr", instr_o,                32'hA5A5_A5A1);
    chk("resume_req",  {31'b0, imem_req_o},    32'h1);
    chk("resume_addr", imem_addr_o,            32'h8);
    adv();

    // Refill to full, then a one-cycle reset mid-stream
    instr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(); adv();
    end
    drive();
    chk("full_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("full_pc",    instr_pc_o,             32'h8);
    chk("full_req",   {31'b0, imem_req_o},    32'h0);
    adv();
    reset_n = 1'b0;
    drive(); adv();

    // After reset: redirect with two requests outstanding
    reset_n       = 1'b1;
    instr_ready_i = 1'b1;
    resp_en       = 1'b0;
    drive();
    chk("mrst_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("mrst_addr",  imem_addr_o,            32'h0);
    chk("mrst_req",   {31'b0, imem_req_o},    32'h1);
    chk("mrst_pc",    instr_pc_o,             32'h0);
    adv();
    drive();
    chk("r2_addr", imem_addr_o, 32'h4);
    adv();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    drive();
    chk("rd_req",   {31'b0, imem_req_o},    32'h0);
    chk("rd_valid", {31'b0, instr_valid_o}, 32'h0);
    adv();
    redirect_i = 1'b0;
    resp_en    = 1'b1;
    drive();
    chk("r4_addr",  imem_addr_o,            32'h100);
    chk("r4_req",   {31'b0, imem_req_o},    32'h0);
    chk("r4_valid", {31'b0, instr_valid_o}, 32'h0);
    adv();
    drive();
    chk("r5_req",   {31'b0, imem_req_o},    32'h1);
    chk("r5_addr",  imem_addr_o,            32'h100);
    chk("r5_valid", {31'b0, instr_valid_o}, 32'h0);
    adv();
    drive();
    chk("r6_addr",  imem_addr_o,            32'h104);
    chk("r6_valid", {31'b0, instr_valid_o}, 32'h0);
    adv();
    drive();
    chk("r7_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("r7_pc",    instr_pc_o,             32'h100);
    chk("r7_instr", instr_o,                32'hA5A5_A4A5);
    adv();
    drive();
    chk("r8_pc",    instr_pc_o,             32'h104);
    chk("r8_instr", instr_o,                32'hA5A5_A4A1);
    chk("r8_addr",  imem_addr_o,            32'h108);
    adv();

    // Redirect to an unaligned PC coincident with a response
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h102;
    drive();
    chk("rv_rvalid_setup", {31'b0, imem_rvalid_i}, 32'h1);
    chk("rv_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("rv_req",   {31'b0, imem_req_o},    32'h0);
    adv();
    redirect_i = 1'b0;
    drive();
    chk("rv10_req",  {31'b0, imem_req_o}, 32'h1);
    chk("rv10_addr", imem_addr_o,         32'h100);
    adv();
    drive();
    chk("rv11_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("rv11_addr",  imem_addr_o,            32'h104);
    adv();
    drive();
    chk("rv12_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("rv12_pc",    instr_pc_o,             32'h100);
    chk("rv12_instr", instr_o,                32'hA5A5_A4A5);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
